// File: rtl/qspi_bus_arb.sv
// qspi_bus_arb: round-robin arbiter sharing one QSPI pad bus among NUM_REQ requesters.
// The owner drives the pads combinationally; all chip selects idle for GAP_CYC cycles
// between owners, and an owner holding the bus for TMO_CYC cycles is evicted and locked
// out until it drops its request.
module qspi_bus_arb #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned GAP_CYC = 4,
  parameter int unsigned TMO_CYC = 65535
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NUM_REQ-1:0]     req_i,
  input  logic [2*NUM_REQ-1:0]   cs_sel_i,
  input  logic [NUM_REQ-1:0]     sck_i,
  input  logic [NUM_REQ-1:0]     nss_i,
  input  logic [4*NUM_REQ-1:0]   dat_i,
  input  logic [4*NUM_REQ-1:0]   dat_oe_i,
  output logic [NUM_REQ-1:0]     gnt_o,
  output logic                   qspi_sck_o,
  output logic [3:0]             qspi_nss_o,
  output logic [3:0]             qspi_dat_o,
  output logic [3:0]             qspi_dat_oe_o,
  input  logic [3:0]             qspi_dat_i,
  output logic [3:0]             rd_dat_o,
  output logic [1:0]             owner_o,
  output logic                   busy_o,
  output logic                   tmo_o
);

  typedef enum logic [1:0] {StIdle, StOwn, StGap} state_e;

  localparam logic [15:0] GapLast = 16'(GAP_CYC - 1);
  localparam logic [15:0] TmoLast = 16'(TMO_CYC - 1);

  state_e      state_q;
  logic [1:0]  last_q;
  logic [1:0]  cs_q;
  logic [15:0] cnt_q;     // hold counter in OWN, gap counter in GAP
  logic [3:0]  block_q;   // requesters locked out after a timeout

  // Per-requester vectors zero-padded to the 4-requester maximum so that the
  // 2-bit owner/winner index always selects within range.
  logic [3:0]  req4, elig4, sck4, nss4, win_oh, owner_oh;
  logic [7:0]  cs8;
  logic [15:0] dat16, oe16;
  logic        win_vld;
  logic [1:0]  win_idx;
  logic [1:0]  cand;

  assign req4     = 4'(req_i);
  assign sck4     = 4'(sck_i);
  assign nss4     = 4'(nss_i);
  assign cs8      = 8'(cs_sel_i);
  assign dat16    = 16'(dat_i);
  assign oe16     = 16'(dat_oe_i);
  assign elig4    = req4 & ~block_q;
  assign win_oh   = 4'b0001 << win_idx;
  assign owner_oh = 4'b0001 << owner_o;
  assign rd_dat_o = qspi_dat_i;

  // Round-robin pick: first eligible requester after the last owner.
  always_comb begin
    win_vld = 1'b0;
    win_idx = 2'd0;
    cand    = 2'd0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = 2'((32'(last_q) + k) % NUM_REQ);
      if (!win_vld && elig4[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  // Arbitration FSM with registered grant, busy, owner and timeout pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      gnt_o   <= '0;
      busy_o  <= 1'b0;
      tmo_o   <= 1'b0;
      owner_o <= 2'd0;
      last_q  <= 2'(NUM_REQ - 1);
      cs_q    <= 2'd0;
      cnt_q   <= 16'd0;
      block_q <= 4'd0;
    end else begin
      tmo_o   <= 1'b0;
      // Dropping the request for a cycle lifts a timeout lockout.
      block_q <= block_q & req4;
      unique case (state_q)
        StIdle: begin
          if (win_vld) begin
            state_q <= StOwn;
            gnt_o   <= win_oh[NUM_REQ-1:0];
            busy_o  <= 1'b1;
            owner_o <= win_idx;
            last_q  <= win_idx;
            cs_q    <= cs8[{win_idx, 1'b0} +: 2];
            cnt_q   <= 16'd0;
          end
        end
        StOwn: begin
          if (!req4[owner_o]) begin
            state_q <= StGap;
            gnt_o   <= '0;
            busy_o  <= 1'b0;
            cnt_q   <= 16'd0;
          end else if (cnt_q == TmoLast) begin
            state_q <= StGap;
            gnt_o   <= '0;
            busy_o  <= 1'b0;
            tmo_o   <= 1'b1;
            cnt_q   <= 16'd0;
            block_q <= (block_q & req4) | owner_oh;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        StGap: begin
          if (cnt_q == GapLast) begin
            state_q <= StIdle;
            cnt_q   <= 16'd0;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Pad mux: owner drives the pads in OWN, everything idle otherwise.
  always_comb begin
    qspi_sck_o    = 1'b0;
    qspi_nss_o    = 4'hF;
    qspi_dat_o    = 4'h0;
    qspi_dat_oe_o = 4'h0;
    if (state_q == StOwn) begin
      qspi_sck_o       = sck4[owner_o];
      qspi_nss_o[cs_q] = nss4[owner_o];
      qspi_dat_o       = dat16[{owner_o, 2'b00} +: 4];
      qspi_dat_oe_o    = oe16[{owner_o, 2'b00} +: 4];
    end
  end

endmodule

// File: tb/tb_qspi_bus_arb.sv
// tb_qspi_bus_arb: table vectors for the pad mux, directed arbitration/timeout/reset
// sequences, random traffic against a cycle model, and JEDEC ID reads from a flash model.
module tb_qspi_bus_arb;

  localparam int NR  = 3;
  localparam int GAP = 4;
  localparam int TMO = 100;

  logic        clk, rst;
  logic [2:0]  req, sck, nss, gnt;
  logic [5:0]  cs_sel;
  logic [11:0] dat, oe;
  logic        q_sck, busy, tmo;
  logic [3:0]  q_nss, q_dat, q_oe, q_din, rd_dat;
  logic [1:0]  owner;

  int checks = 0;
  int failures = 0;
  int tmo_seen = 0;

  qspi_bus_arb #(.NUM_REQ(NR), .GAP_CYC(GAP), .TMO_CYC(TMO)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .cs_sel_i(cs_sel), .sck_i(sck), .nss_i(nss),
    .dat_i(dat), .dat_oe_i(oe), .gnt_o(gnt), .qspi_sck_o(q_sck), .qspi_nss_o(q_nss),
    .qspi_dat_o(q_dat), .qspi_dat_oe_o(q_oe), .qspi_dat_i(q_din), .rd_dat_o(rd_dat),
    .owner_o(owner), .busy_o(busy), .tmo_o(tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // W25Q-style flash on cs0/cs1: mode-0 SPI, answers 0x9F with the JEDEC ID on IO1.
  logic        miso = 1'b0;
  logic [7:0]  fl_cmd = 8'h00;
  logic [23:0] fl_sr = 24'hEF4018;
  int          fl_bits = 0;
  int          fl_cs = -1;
  logic        fl_sck_q = 1'b0;
  assign q_din = {2'b00, miso, 1'b0};

  always @(q_sck or q_nss) begin
    if (q_nss[1:0] == 2'b11) begin
      fl_bits = 0;
      miso    = 1'b0;
      fl_sr   = 24'hEF4018;
    end else begin
      fl_cs = q_nss[0] ? 1 : 0;
      if (q_sck && !fl_sck_q && fl_bits < 8) begin
        fl_cmd  = {fl_cmd[6:0], q_dat[0]};
        fl_bits = fl_bits + 1;
      end else if (!q_sck && fl_sck_q && fl_bits == 8 && fl_cmd == 8'h9F) begin
        miso  = fl_sr[23];
        fl_sr = {fl_sr[22:0], 1'b0};
      end
    end
    fl_sck_q = q_sck;
  end

  // Reference model: owner/gap bookkeeping derived from the arbitration rules.
  bit         m_own, m_tmo;
  int         m_owner, m_last, m_gap, m_hold, m_cs;
  logic [2:0] m_blk;

  task automatic model_reset();
    m_own = 0; m_tmo = 0; m_owner = 0; m_last = NR - 1; m_gap = 0; m_hold = 0; m_cs = 0;
    m_blk = 3'b000;
  endtask

  task automatic model_step();
    logic [2:0] pend;
    int w, idx;
    m_tmo = 0;
    pend  = req & ~m_blk;
    if (m_gap > 0) begin
      m_gap--;
    end else if (m_own) begin
      if (!req[m_owner]) begin
        m_own = 0; m_gap = GAP;
      end else if (m_hold == TMO - 1) begin
        m_own = 0; m_gap = GAP; m_tmo = 1; m_blk[m_owner] = 1'b1;
      end else begin
        m_hold++;
      end
    end else begin
      w = -1;
      for (int k = NR; k >= 1; k--) begin
        idx = (m_last + k) % NR;
        if (pend[idx]) w = idx;
      end
      if (w >= 0) begin
        m_own = 1; m_owner = w; m_last = w; m_hold = 0; m_cs = int'(cs_sel[2*w +: 2]);
      end
    end
    m_blk = m_blk & req;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_pads();
    logic       e_sck;
    logic [3:0] e_nss, e_dat, e_oe;
    e_sck = 1'b0; e_nss = 4'hF; e_dat = 4'h0; e_oe = 4'h0;
    if (m_own) begin
      e_sck = sck[m_owner];
      e_nss[m_cs] = nss[m_owner];
      e_dat = dat[m_owner*4 +: 4];
      e_oe  = oe[m_owner*4 +: 4];
    end
    chk("pad_sck", 32'(q_sck), 32'(e_sck));
    chk("pad_nss", 32'(q_nss), 32'(e_nss));
    chk("pad_dat", 32'(q_dat), 32'(e_dat));
    chk("pad_oe", 32'(q_oe), 32'(e_oe));
  endtask

  // One clock: check pads for current inputs, advance model, check registered outputs.
  task automatic cycle();
    logic [2:0] e_gnt;
    #1;
    check_pads();
    model_step();
    @(posedge clk);
    #1;
    e_gnt = m_own ? (3'b001 << m_owner) : 3'b000;
    chk("gnt_o", 32'(gnt), 32'(e_gnt));
    chk("busy_o", 32'(busy), 32'(m_own));
    chk("tmo_o", 32'(tmo), 32'(m_tmo));
    chk("owner_o", 32'(owner), 32'(m_owner));
    if (tmo) tmo_seen++;
  endtask

  task automatic wait_gnt(input int r, input int max, input string name);
    int n;
    n = 0;
    while (!gnt[r] && n < max) begin
      cycle();
      n++;
    end
    chk(name, 32'(gnt[r]), 32'd1);
  endtask

  task automatic jedec(input int r);
    logic [23:0] id;
    logic [7:0]  cmd;
    cmd = 8'h9F;
    id  = 24'h0;
    cs_sel[r*2 +: 2] = 2'(r);
    req[r] = 1'b1;
    wait_gnt(r, 20, "jedec_gnt");
    nss[r] = 1'b0;
    oe[r*4 +: 4] = 4'b0001;
    cycle();
    for (int b = 7; b >= 0; b--) begin
      dat[r*4] = cmd[b]; sck[r] = 1'b0; cycle();
      sck[r] = 1'b1; cycle();
    end
    for (int b = 0; b < 24; b++) begin
      sck[r] = 1'b0; cycle();
      id = {id[22:0], rd_dat[1]};
      sck[r] = 1'b1; cycle();
    end
    chk("jedec_cs", 32'(fl_cs), 32'(r));
    sck[r] = 1'b0; nss[r] = 1'b1; oe = 12'h0; dat = 12'h0; req[r] = 1'b0;
    repeat (GAP + 3) cycle();
    chk("jedec_id", 32'(id), 32'h00EF4018);
  endtask

  typedef struct {
    logic [5:0]  cs_sel;
    logic [2:0]  sck, nss;
    logic [11:0] dat, oe;
    logic        e_sck;
    logic [3:0]  e_nss, e_dat, e_oe;
  } vec_t;

  vec_t tbl[5];
  int   grants[$];
  int   exp_order[4];

  initial begin
    int held[3];
    logic [2:0] prev;
    int run, n, n0;
    bit started;

    // Owner 1 with cs latched as 2; later cs_sel changes must not move the select.
    tbl[0] = '{6'b001000, 3'b010, 3'b000, 12'h5A3, 12'hF0F, 1'b1, 4'b1011, 4'hA, 4'h0};
    tbl[1] = '{6'b000000, 3'b101, 3'b101, 12'h0C0, 12'h0F0, 1'b0, 4'b1011, 4'hC, 4'hF};
    tbl[2] = '{6'b111111, 3'b111, 3'b010, 12'hF3F, 12'h050, 1'b1, 4'hF,    4'h3, 4'h5};
    tbl[3] = '{6'b010101, 3'b000, 3'b111, 12'h987, 12'h000, 1'b0, 4'hF,    4'h8, 4'h0};
    tbl[4] = '{6'b100001, 3'b010, 3'b001, 12'h1E2, 12'h3C0, 1'b1, 4'b1011, 4'hE, 4'hC};
    exp_order = '{0, 1, 2, 0};

    // Reset with busy-looking inputs: pads must stay idle.
    rst = 1'b0; req = 3'b000; cs_sel = 6'h3F; sck = 3'b111; nss = 3'b000;
    dat = 12'hFFF; oe = 12'hFFF;
    #1 rst = 1'b1;
    #1;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tmo", 32'(tmo), 32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_nss", 32'(q_nss), 32'hF);
    chk("rst_sck", 32'(q_sck), 32'd0);
    chk("rst_dat", 32'(q_dat), 32'd0);
    chk("rst_oe", 32'(q_oe), 32'd0);
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    cs_sel = 6'h00; sck = 3'b000; nss = 3'b111; dat = 12'h0; oe = 12'h0;

    // All three request, each drops after 10 owned cycles and re-requests.
    req = 3'b111; held = '{0, 0, 0}; prev = 3'b000; run = 0; started = 0;
    for (int c = 0; c < 64; c++) begin
      cycle();
      if (gnt != 3'b000 && prev == 3'b000) begin
        for (int i = 0; i < NR; i++) if (gnt[i]) grants.push_back(i);
        if (started) chk("gap_cycles", 32'(run), 32'(GAP + 1));
        started = 1;
        run = 0;
      end
      if (!busy) run++;
      prev = gnt;
      for (int i = 0; i < NR; i++) begin
        if (gnt[i]) begin
          held[i]++;
          if (held[i] == 10) begin req[i] = 1'b0; held[i] = 0; end
        end else begin
          req[i] = 1'b1;
        end
      end
    end
    chk("grant_count_ok", 32'(grants.size() >= 4), 32'd1);
    for (int k = 0; k < 4; k++)
      chk("grant_order", (k < grants.size()) ? 32'(grants[k]) : 32'hFFFF, 32'(exp_order[k]));
    req = 3'b000;
    repeat (12) cycle();

    // Single requester 2 pulsing: 1-cycle grant latency, gap enforced each time.
    req = 3'b100;
    cycle();
    chk("grant_latency", 32'(gnt), 32'b100);
    for (int t = 0; t < 3; t++) begin
      repeat (3) cycle();
      req[2] = 1'b0; cycle(); req[2] = 1'b1;
      n = 1;
      while (!gnt[2] && n < 20) begin
        cycle();
        if (!gnt[2]) n++;
      end
      chk("regrant_gap", 32'(n), 32'(GAP + 1));
    end
    req = 3'b000;
    repeat (8) cycle();

    // Timeout: owner 0 holds forever, requester 1 waits.
    tmo_seen = 0;
    req = 3'b011;
    wait_gnt(0, 5, "tmo_gnt0");
    n = 1;
    while (gnt[0] && n < 200) begin
      cycle();
      if (gnt[0]) n++;
    end
    chk("hold_cycles", 32'(n), 32'(TMO));
    wait_gnt(1, 20, "tmo_gnt1");
    repeat (5) cycle();
    req[1] = 1'b0;
    n0 = 0;
    repeat (15) begin
      cycle();
      if (gnt[0]) n0++;
    end
    chk("no_regrant", 32'(n0), 32'd0);
    chk("tmo_pulses", 32'(tmo_seen), 32'd1);
    req[0] = 1'b0; cycle(); req[0] = 1'b1;
    wait_gnt(0, 20, "regrant_after_toggle");
    req = 3'b000;
    repeat (8) cycle();

    // Reset during OWN: selects release immediately, then requester 1 wins first.
    cs_sel = 6'b000001; nss = 3'b110; req = 3'b001;
    wait_gnt(0, 20, "pre_rst_gnt");
    cycle();
    chk("own_nss_cs1", 32'(q_nss), 32'b1101);
    rst = 1'b1;
    #1;
    chk("rst_async_nss", 32'(q_nss), 32'hF);
    chk("rst_async_gnt", 32'(gnt), 32'd0);
    chk("rst_async_busy", 32'(busy), 32'd0);
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    cs_sel = 6'b001000; nss = 3'b111; req = 3'b110;
    cycle();
    chk("post_rst_first", 32'(gnt), 32'b010);

    // Pad mux table while requester 1 owns with cs 2.
    for (int v = 0; v < 5; v++) begin
      cs_sel = tbl[v].cs_sel; sck = tbl[v].sck; nss = tbl[v].nss;
      dat = tbl[v].dat; oe = tbl[v].oe;
      #1;
      chk("tbl_sck", 32'(q_sck), 32'(tbl[v].e_sck));
      chk("tbl_nss", 32'(q_nss), 32'(tbl[v].e_nss));
      chk("tbl_dat", 32'(q_dat), 32'(tbl[v].e_dat));
      chk("tbl_oe", 32'(q_oe), 32'(tbl[v].e_oe));
      cycle();
    end
    req = 3'b000; sck = 3'b000; nss = 3'b111; dat = 12'h0; oe = 12'h0;
    repeat (8) cycle();

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NR; i++) if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
      cs_sel = 6'($urandom); sck = 3'($urandom); nss = 3'($urandom);
      dat = 12'($urandom); oe = 12'($urandom);
      cycle();
    end
    req = 3'b000; sck = 3'b000; nss = 3'b111; dat = 12'h0; oe = 12'h0; cs_sel = 6'h0;
    repeat (GAP + 3) cycle();
    req = 3'b000;
    repeat (2) cycle();

    // JEDEC ID from the flashes on cs0 (requester 0) and cs1 (requester 1).
    jedec(0);
    jedec(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
